// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional one-cycle early-out for |dividend| < |divisor| under `DIV_EARLY_OUT_EN.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              annul_i,
  input  logic              signed_div_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output logic              ready_o,
  output logic              stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, ON, END} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   pr_q, pr_d;
  logic [DATA_W-1:0]   dq_q, dq_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic                ready_q, ready_d;

  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     shifted, diff;
  logic                q_bit;
  logic [DATA_W-1:0]   pr_step, q_step;

  // dq_q starts as the dividend magnitude and fills with quotient bits from the LSB
  always_comb begin
    a_neg   = signed_div_i & dividend_i[DATA_W-1];
    b_neg   = signed_div_i & divisor_i[DATA_W-1];
    a_mag   = a_neg ? -dividend_i : dividend_i;
    b_mag   = b_neg ? -divisor_i : divisor_i;
    shifted = {pr_q, dq_q[DATA_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    q_bit   = ~diff[DATA_W];
    pr_step = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    q_step  = {dq_q[DATA_W-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            quo_d   = '1;
            rem_d   = dividend_i;
            state_d = END;
          end else if (signed_div_i && dividend_i == {1'b1, {(DATA_W-1){1'b0}}}
                       && divisor_i == '1) begin
            quo_d   = {1'b1, {(DATA_W-1){1'b0}}};
            rem_d   = '0;
            state_d = END;
`ifdef DIV_EARLY_OUT_EN
          end else if (a_mag < b_mag) begin
            quo_d   = '0;
            rem_d   = dividend_i;
            state_d = END;
`endif
          end else begin
            cnt_d   = '0;
            pr_d    = '0;
            dq_d    = a_mag;
            dvs_d   = b_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = ON;
          end
        end
      end
      ON: begin
        cnt_d = cnt_q + 1'b1;
        pr_d  = pr_step;
        dq_d  = q_step;
        if (cnt_q == CNT_W'(DATA_W-1)) begin
          quo_d   = qneg_q ? -q_step : q_step;
          rem_d   = rneg_q ? -pr_step : pr_step;
          cnt_d   = '0;
          state_d = END;
        end
      end
      END: begin
        if (!start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush drops the operation but leaves the last published result intact
    if (annul_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      quo_d   = quo_q;
      rem_d   = rem_q;
    end

    ready_d = (state_d == END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign ready_o     = ready_q;
  assign stallreq_o  = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, popped when ready_o rises.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        annul;
  logic        sgn;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ready;
  logic        stallreq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .annul_i      (annul),
    .signed_div_i (sgn),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] am, bm;
    am    = (s && a[31]) ? -a : a;
    bm    = (s && b[31]) ? -b : b;
    e.lat = 33;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.lat = 1;
    end else if (s) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
`ifdef DIV_EARLY_OUT_EN
    if (b != 32'd0 && !(s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) && am < bm)
      e.lat = 1;
`else
    if (am == bm && am == 32'hDEAD_0000) e.lat = 33;
`endif
    return e;
  endfunction

  // Call right after a negedge; returns in the idle cycle following the result.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
    exp_t e;
    int   c = 0;
    int   stalls = 0;
    bit   got = 0;
    sb.push_back(model(s, a, b));
    sgn = s; dividend = a; divisor = b; start = 1'b1;
    #1;
    while (!got && c <= 100) begin
      if (ready === 1'b1) got = 1;
      else begin
        if (stallreq === 1'b1) stalls++;
        @(negedge clk); #1; c++;
      end
    end
    e = sb.pop_front();
    total_cnt++;
    if (!got) begin
      $display("FAIL %s_timeout ready_o never rose within %0d cycles", tag, c);
      start = 1'b0;
      @(negedge clk); #1;
      return;
    end else pass_cnt++;
    total_cnt++;
    if (quotient !== e.q) $display("FAIL %s_quot got %h want %h", tag, quotient, e.q);
    else pass_cnt++;
    total_cnt++;
    if (remainder !== e.r) $display("FAIL %s_rem got %h want %h", tag, remainder, e.r);
    else pass_cnt++;
    total_cnt++;
    if (c !== e.lat) $display("FAIL %s_latency got %0d want %0d", tag, c, e.lat);
    else pass_cnt++;
    total_cnt++;
    if (stalls !== e.lat) $display("FAIL %s_stalls got %0d want %0d", tag, stalls, e.lat);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); #1;
    total_cnt++;
    if (ready !== 1'b0 || stallreq !== 1'b0)
      $display("FAIL %s_release ready=%b stallreq=%b want 0 0", tag, ready, stallreq);
    else pass_cnt++;
  endtask

  task automatic expect_quiet(input int n, input string tag);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      if (ready !== 1'b0) seen = 1;
    end
    total_cnt++;
    if (seen) $display("FAIL %s ready_o rose, want it held at 0", tag);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; sgn = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if (ready !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || stallreq !== 1'b0)
      $display("FAIL reset_outputs ready=%b q=%h r=%h stall=%b want all 0",
               ready, quotient, remainder, stallreq);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    #1;
    total_cnt++;
    if (stallreq !== 1'b1) $display("FAIL reset_stall_follow got %b want 1", stallreq);
    else pass_cnt++;
    start = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_divu();
    do_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    do_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "divu_max_maxm1");
  endtask

  task automatic test_signed();
    do_div(1'b1, -32'sd100, 32'd7, "div_m100_7");
    do_div(1'b1, 32'd100, -32'sd7, "rem_100_m7");
    do_div(1'b1, -32'sd100, -32'sd7, "div_m100_m7");
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_ovf_pattern");
  endtask

  task automatic test_special();
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    do_div(1'b0, 32'h0000_1234, 32'd0, "divu_by_zero");
    do_div(1'b1, -32'sd5, 32'd0, "div_neg_by_zero");
  endtask

  task automatic test_early_out();
    do_div(1'b0, 32'd5, 32'd9, "divu_5_9");
    do_div(1'b1, -32'sd5, 32'd9, "div_m5_9");
    do_div(1'b1, 32'd9, -32'sd9, "div_9_m9");
  endtask

  task automatic test_annul();
    sgn = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    annul = 1'b1;
    #1;
    total_cnt++;
    if (stallreq !== 1'b0) $display("FAIL annul_stall got %b want 0", stallreq);
    else pass_cnt++;
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    #1;
    total_cnt++;
    if (ready !== 1'b0 || stallreq !== 1'b0)
      $display("FAIL annul_idle ready=%b stall=%b want 0 0", ready, stallreq);
    else pass_cnt++;
    expect_quiet(40, "annul_no_result");
    start = 1'b1; annul = 1'b1;
    #1;
    total_cnt++;
    if (stallreq !== 1'b0) $display("FAIL annul_start_idle_stall got %b want 0", stallreq);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    start = 1'b0; annul = 1'b0;
    expect_quiet(40, "annul_start_idle_no_op");
    do_div(1'b0, 32'd9, 32'd3, "divu_9_3_after_annul");
  endtask

  task automatic test_reset_mid();
    sgn = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'd17; start = 1'b1;
    for (int i = 1; i <= 20; i++) @(negedge clk);
    rst = 1'b1; annul = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0; annul = 1'b0;
    #1;
    total_cnt++;
    if (ready !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || stallreq !== 1'b0)
      $display("FAIL reset_mid_outputs ready=%b q=%h r=%h stall=%b want all 0",
               ready, quotient, remainder, stallreq);
    else pass_cnt++;
    expect_quiet(40, "reset_mid_no_stale_ready");
  endtask

  task automatic test_back_to_back();
    do_div(1'b0, 32'd1000, 32'd10, "b2b_0");
    do_div(1'b1, -32'sd1000, 32'd33, "b2b_1");
    do_div(1'b0, 32'd77, 32'd0, "b2b_2");
    do_div(1'b1, 32'h7FFF_FFFF, -32'sd2, "b2b_3");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom_range(1, 255);
        1: b = $urandom;
        2: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: b = (i == 11) ? 32'd0 : $urandom_range(1, 65535);
      endcase
      do_div(logic'(i[0]), a, b, $sformatf("rand_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_special();
    test_early_out();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    test_random();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
